pes_serial_adder: RTL and testbench
===================================

PES_SERIAL_ADDER -- requirements
Module: pes_serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand and sum width in bits.
REQ-002 Parameter DIGIT_W, default 2, bits added per clock cycle.
REQ-003 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  reset; synchronous, active-high.
REQ-005 i_valid  input  1  request: operands present on i_a/i_b/i_cin.
REQ-006 o_ready  output  1  block can accept a request.
REQ-007 i_a  input  WIDTH  operand A.
REQ-008 i_b  input  WIDTH  operand B.
REQ-009 i_cin  input  1  carry-in.
REQ-010 o_valid  output  1  result present on o_sum/o_carry.
REQ-011 i_ready  input  1  consumer takes the result.
REQ-012 o_sum  output  WIDTH  sum bits.
REQ-013 o_carry  output  1  carry out of the MSB.
REQ-014 o_busy  output  1  addition in progress.

Function
REQ-015 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-016 NDIG = WIDTH/DIGIT_W; elaboration SHALL fail if WIDTH < 1, DIGIT_W < 1, or WIDTH mod DIGIT_W != 0.
REQ-017 o_ready SHALL be 1 only in IDLE; o_busy 1 only in BUSY; o_valid 1 only in DONE.
REQ-018 Acceptance SHALL occur on an edge with i_valid=1 and o_ready=1: i_a, i_b and i_cin are captured, the digit counter is cleared, and the state goes IDLE->BUSY.
REQ-019 Each BUSY cycle SHALL add digit k (bits k*DIGIT_W..k*DIGIT_W+DIGIT_W-1, LSB digit first) of the captured operands plus the running carry, store the DIGIT_W result bits, and update the running carry.
REQ-020 The running carry SHALL start at the captured i_cin.
REQ-021 After the edge processing digit NDIG-1, the state SHALL be DONE.
REQ-022 o_valid SHALL rise on the NDIG-th rising edge after the acceptance edge (DIGIT_W=WIDTH gives 1 cycle).
REQ-023 In DONE, o_sum and o_carry SHALL equal {o_carry,o_sum} = i_a + i_b + i_cin (WIDTH+1-bit result, no truncation) and be held stable.
REQ-024 DONE SHALL go to IDLE on an edge with i_ready=1; with i_ready=0 DONE and the result hold indefinitely.
REQ-025 i_valid SHALL be ignored outside IDLE; changes on i_a, i_b and i_cin after acceptance SHALL have no effect on the result.
REQ-026 o_sum and o_carry SHALL keep the last result in IDLE until the next completion; in BUSY they are don't-care.
REQ-027 i_ready outside DONE SHALL have no effect.

Reset
REQ-028 On a rising edge with i_rst=1, the state SHALL become IDLE and the digit counter, running carry, o_sum and o_carry SHALL clear to 0.
REQ-029 After reset, outputs SHALL be o_ready=1, o_valid=0, o_busy=0, o_sum=0, o_carry=0.
REQ-030 Reset SHALL take priority over i_valid and i_ready.
REQ-031 Reset asserted during BUSY or DONE SHALL abort the operation with no o_valid pulse; the result is discarded.

Structure
REQ-032 A shared package pes_adder_pkg SHALL hold the state encoding (IDLE=0, BUSY=1, DONE=2, 2 bits) and the NDIG and counter-width (clog2 of NDIG, minimum 1) helper constants.
REQ-033 One combinational sub-module, pes_digit_adder (parameter DIGIT_W; inputs i_a, i_b, i_cin; outputs o_sum, o_carry), SHALL implement the per-cycle digit addition.
REQ-034 All other logic SHALL be a single clocked process plus output decode.

Verification (WIDTH=8, DIGIT_W=2 unless stated)
REQ-035 Basic: i_a=8'h3C, i_b=8'h05, i_cin=0 accepted -> o_busy for 4 cycles, then o_valid=1, o_sum=8'h41, o_carry=0.
REQ-036 Overflow/carry chain: 8'hFF + 8'h00 + i_cin=1 -> o_sum=8'h00, o_carry=1; 8'hFF + 8'h01 -> o_sum=8'h00, o_carry=1.
REQ-037 Backpressure: hold i_ready=0 for 10 cycles in DONE -> o_valid and the result stay stable; i_valid pulses with new operands during this time are ignored; i_ready=1 -> IDLE next edge with o_ready=1.
REQ-038 Input isolation: change i_a and i_b every BUSY cycle -> result equals the sum of the operands captured at acceptance.
REQ-039 Reset mid-operation: assert i_rst in the 2nd BUSY cycle -> next edge shows o_ready=1, o_valid=0, o_sum=0, o_carry=0, and no o_valid follows.
REQ-040 Parametric sweep: (WIDTH,DIGIT_W) in {(8,8),(8,1),(16,4)} with 200 random operands each -> latency NDIG and result matching a reference model, with a self-checking pass/fail line per case.

Source files
------------

// File: rtl/pes_adder_pkg.sv
// Shared encodings and sizing helpers for the digit-serial adder.
// Both helpers are evaluated at elaboration time.
package pes_adder_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Number of digits per operand; zero flags an illegal digit width.
    function automatic int calc_ndig(input int width, input int digit_w);
        return (digit_w > 0) ? width / digit_w : 0;
    endfunction

    // Digit counter width, never narrower than one bit.
    function automatic int calc_cnt_w(input int ndig);
        return (ndig < 2) ? 1 : $clog2(ndig);
    endfunction

endpackage

// File: rtl/pes_digit_adder.sv
// Combinational DIGIT_W-bit adder with carry in and carry out.
module pes_digit_adder #(
    parameter int DIGIT_W = 2
) (
    input  logic [DIGIT_W-1:0] i_a,
    input  logic [DIGIT_W-1:0] i_b,
    input  logic               i_cin,
    output logic [DIGIT_W-1:0] o_sum,
    output logic               o_carry
);

    assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{DIGIT_W{1'b0}}, i_cin};

endmodule

// File: rtl/pes_serial_adder.sv
// Digit-serial adder: adds two WIDTH-bit operands DIGIT_W bits per clock,
// LSB digit first, with a valid/ready handshake on both sides.
module pes_serial_adder
    import pes_adder_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DIGIT_W = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_busy
);

    localparam int NDIG  = calc_ndig(WIDTH, DIGIT_W);
    localparam int CNT_W = calc_cnt_w(NDIG);
    localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

    if (WIDTH < 1 || DIGIT_W < 1 || (WIDTH % DIGIT_W) != 0) begin : g_bad_param
        $error("pes_serial_adder: WIDTH must be a positive multiple of DIGIT_W");
    end

    logic [1:0]         state;
    logic [CNT_W-1:0]   dig_cnt;
    logic               run_carry;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   sum_q;
    logic               carry_q;
    logic [DIGIT_W-1:0] dig_sum;
    logic               dig_carry;
    logic [WIDTH-1:0]   sum_next;

    // Operands shift right each cycle, so the current digit is always the low slice.
    pes_digit_adder #(
        .DIGIT_W(DIGIT_W)
    ) u_digit_adder (
        .i_a    (a_q[DIGIT_W-1:0]),
        .i_b    (b_q[DIGIT_W-1:0]),
        .i_cin  (run_carry),
        .o_sum  (dig_sum),
        .o_carry(dig_carry)
    );

    // Result digits enter at the top and walk down; after NDIG shifts they sit in place.
    if (DIGIT_W == WIDTH) begin : g_single_digit
        assign sum_next = dig_sum;
    end else begin : g_multi_digit
        assign sum_next = {dig_sum, sum_q[WIDTH-1:DIGIT_W]};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            dig_cnt   <= '0;
            run_carry <= 1'b0;
            sum_q     <= '0;
            carry_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        a_q       <= i_a;
                        b_q       <= i_b;
                        run_carry <= i_cin;
                        dig_cnt   <= '0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    a_q       <= a_q >> DIGIT_W;
                    b_q       <= b_q >> DIGIT_W;
                    sum_q     <= sum_next;
                    run_carry <= dig_carry;
                    dig_cnt   <= dig_cnt + 1'b1;
                    if (dig_cnt == LAST_DIG) begin
                        carry_q <= dig_carry;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_ready = (state == IDLE);
    assign o_busy  = (state == BUSY);
    assign o_valid = (state == DONE);
    assign o_sum   = sum_q;
    assign o_carry = carry_q;

endmodule

// File: tb/tb_pes_serial_adder.sv
// Scoreboard bench: drivers push expected sums, monitors pop them when o_valid rises.
module tb_pes_serial_adder;

    localparam int W    = 8;
    localparam int D    = 2;
    localparam int NDIG = W / D;
    localparam int W1   = W + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int chk_cnt     = 0;
    int pass_cnt    = 0;
    int cyc         = 0;
    int valid_rises = 0;
    int policy      = 0;
    int snap        = 0;
    bit prev        = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic bit check(input string name, input logic [63:0] act,
                                 input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
            return 1'b1;
        end
        $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        return 1'b0;
    endfunction

    logic         rst, in_valid, cin, take;
    logic         ready, out_valid, busy, carry;
    logic [W-1:0] a, b, sum;
    logic [W:0]   exp_q[$];
    int           acc_q[$];
    logic [W:0]   hold;

    pes_serial_adder #(
        .WIDTH  (W),
        .DIGIT_W(D)
    ) u_dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_valid(in_valid),
        .o_ready(ready),
        .i_a    (a),
        .i_b    (b),
        .i_cin  (cin),
        .o_valid(out_valid),
        .i_ready(take),
        .o_sum  (sum),
        .o_carry(carry),
        .o_busy (busy)
    );

    // Consumer: 0 = always take, 1 = random backpressure, 2 = stall.
    initial begin
        take = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (policy)
                0:       take = 1'b1;
                1:       take = ($urandom_range(0, 3) != 0);
                default: take = 1'b0;
            endcase
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst !== 1'b0 || out_valid !== 1'b1) begin
            prev = 1'b0;
        end else if (!prev) begin
            prev = 1'b1;
            valid_rises++;
            if (exp_q.size() == 0) begin
                void'(check("unexpected_valid", 64'(out_valid), 64'd0));
            end else begin
                hold = exp_q.pop_front();
                void'(check("latency", 64'(cyc - acc_q.pop_front()), 64'(NDIG)));
                void'(check("result", 64'({carry, sum}), 64'(hold)));
            end
        end else begin
            void'(check("result_hold", 64'({carry, sum}), 64'(hold)));
        end
    end

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                        input bit expect_res);
        @(negedge clk);
        for (int t = 0; t < 100 && ready !== 1'b1; t++) @(negedge clk);
        void'(check("accept_ready", 64'(ready), 64'd1));
        a        = ta;
        b        = tb_v;
        cin      = tc;
        in_valid = 1'b1;
        if (expect_res) begin
            exp_q.push_back(W1'(ta) + W1'(tb_v) + W1'(tc));
            acc_q.push_back(cyc + 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        cin      = 1'($urandom);
    endtask

    task automatic wait_idle(input int limit);
        for (int t = 0; t < limit && (exp_q.size() != 0 || ready !== 1'b1); t++) begin
            @(negedge clk);
        end
        void'(check("drain", 64'(exp_q.size()), 64'd0));
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_sweep
        localparam int SW  = (g == 2) ? 16 : 8;
        localparam int SD  = (g == 0) ? 8 : ((g == 1) ? 1 : 4);
        localparam int SN  = SW / SD;
        localparam int SW1 = SW + 1;

        logic          s_rst, s_in_valid, s_cin, s_take;
        logic          s_ready, s_out_valid, s_busy, s_carry;
        logic [SW-1:0] s_a, s_b, s_sum;
        logic [SW:0]   s_exp_q[$];
        int            s_acc_q[$];
        logic [SW:0]   s_hold;
        bit            s_prev = 1'b0;
        bit            s_done = 1'b0;
        int            lc     = 0;
        int            lp     = 0;

        pes_serial_adder #(
            .WIDTH  (SW),
            .DIGIT_W(SD)
        ) u_dut (
            .i_clk  (clk),
            .i_rst  (s_rst),
            .i_valid(s_in_valid),
            .o_ready(s_ready),
            .i_a    (s_a),
            .i_b    (s_b),
            .i_cin  (s_cin),
            .o_valid(s_out_valid),
            .i_ready(s_take),
            .o_sum  (s_sum),
            .o_carry(s_carry),
            .o_busy (s_busy)
        );

        function automatic void chk(input string n, input logic [63:0] x,
                                    input logic [63:0] e);
            lc++;
            if (check(n, x, e)) lp++;
        endfunction

        initial begin
            s_take = 1'b0;
            forever begin
                @(posedge clk);
                #1;
                s_take = ($urandom_range(0, 3) != 0);
            end
        end

        initial forever begin
            @(negedge clk);
            if (s_rst !== 1'b0 || s_out_valid !== 1'b1) begin
                s_prev = 1'b0;
            end else if (!s_prev) begin
                s_prev = 1'b1;
                if (s_exp_q.size() == 0) begin
                    chk("sweep_unexpected_valid", 64'(s_out_valid), 64'd0);
                end else begin
                    s_hold = s_exp_q.pop_front();
                    chk("sweep_latency", 64'(cyc - s_acc_q.pop_front()), 64'(SN));
                    chk("sweep_result", 64'({s_carry, s_sum}), 64'(s_hold));
                end
            end else begin
                chk("sweep_hold", 64'({s_carry, s_sum}), 64'(s_hold));
            end
        end

        initial begin
            s_rst      = 1'b1;
            s_in_valid = 1'b0;
            s_a        = '0;
            s_b        = '0;
            s_cin      = 1'b0;
            repeat (2) @(negedge clk);
            s_rst = 1'b0;
            for (int n = 0; n < 200; n++) begin
                @(negedge clk);
                for (int t = 0; t < 100 && s_ready !== 1'b1; t++) @(negedge clk);
                chk("sweep_accept_ready", 64'(s_ready), 64'd1);
                s_a        = SW'($urandom);
                s_b        = SW'($urandom);
                s_cin      = 1'($urandom);
                s_in_valid = 1'b1;
                s_exp_q.push_back(SW1'(s_a) + SW1'(s_b) + SW1'(s_cin));
                s_acc_q.push_back(cyc + 1);
                @(negedge clk);
                s_in_valid = 1'b0;
                s_a        = SW'($urandom);
                s_b        = SW'($urandom);
            end
            for (int t = 0; t < 500 && s_exp_q.size() != 0; t++) @(negedge clk);
            chk("sweep_drain", 64'(s_exp_q.size()), 64'd0);
            $display("sweep WIDTH=%0d DIGIT_W=%0d: %0d errors in %0d checks", SW, SD, lc - lp, lc);
            s_done = 1'b1;
        end
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        repeat (2) @(negedge clk);
        void'(check("reset_ready", 64'(ready), 64'd1));
        void'(check("reset_valid", 64'(out_valid), 64'd0));
        void'(check("reset_busy", 64'(busy), 64'd0));
        void'(check("reset_sum", 64'(sum), 64'd0));
        void'(check("reset_carry", 64'(carry), 64'd0));
        rst = 1'b0;

        send(8'h3C, 8'h05, 1'b0, 1'b1);
        for (int i = 0; i < NDIG; i++) begin
            void'(check("basic_busy", 64'(busy), 64'd1));
            @(negedge clk);
        end
        void'(check("basic_busy_end", 64'(busy), 64'd0));
        void'(check("basic_valid", 64'(out_valid), 64'd1));
        wait_idle(50);

        send(8'hFF, 8'h00, 1'b1, 1'b1);
        send(8'hFF, 8'h01, 1'b0, 1'b1);
        wait_idle(50);

        // Operands wiggle throughout BUSY; only the captured ones may count.
        send(8'hA7, 8'h96, 1'b1, 1'b1);
        for (int i = 0; i < NDIG - 1; i++) begin
            @(negedge clk);
            a   = W'($urandom);
            b   = W'($urandom);
            cin = 1'($urandom);
        end
        wait_idle(50);

        policy = 2;
        send(8'h12, 8'h34, 1'b0, 1'b1);
        for (int t = 0; t < 50 && out_valid !== 1'b1; t++) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            void'(check("bp_valid", 64'(out_valid), 64'd1));
            in_valid = (i % 2) == 1;
            a        = W'($urandom);
            b        = W'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        policy   = 0;
        @(negedge clk);
        void'(check("bp_still_done", 64'(out_valid), 64'd1));
        @(negedge clk);
        void'(check("bp_release_ready", 64'(ready), 64'd1));
        void'(check("bp_release_valid", 64'(out_valid), 64'd0));
        wait_idle(50);

        snap = valid_rises;
        send(8'h55, 8'hAA, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        void'(check("abort_ready", 64'(ready), 64'd1));
        void'(check("abort_valid", 64'(out_valid), 64'd0));
        void'(check("abort_busy", 64'(busy), 64'd0));
        void'(check("abort_sum", 64'(sum), 64'd0));
        void'(check("abort_carry", 64'(carry), 64'd0));
        rst = 1'b0;
        repeat (12) @(negedge clk);
        void'(check("abort_no_valid", 64'(valid_rises), 64'(snap)));

        policy = 1;
        for (int n = 0; n < 200; n++) begin
            send(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
        end
        wait_idle(400);

        for (int t = 0; t < 30000 &&
             !(g_sweep[0].s_done && g_sweep[1].s_done && g_sweep[2].s_done); t++) begin
            @(negedge clk);
        end
        void'(check("sweep_done",
                    64'({g_sweep[2].s_done, g_sweep[1].s_done, g_sweep[0].s_done}), 64'd7));

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
